// File: rtl/cnn_pkg.sv
// ---------------------------------------------------------------------------
// cnn_pkg
// Shared definitions for the CNN job scheduler:
//   - CNN mode_select encodings (MODE_MAC, MODE_RELU, MODE_MAX_POOL)
//   - scheduler FSM state encoding (legacy-compatible localparam constants)
//   - mem_size(): bytes per job (WINDOW*WINDOW pixels followed by as many
//     kernel weights)
// ---------------------------------------------------------------------------
package cnn_pkg;

  localparam logic [1:0] MODE_MAC      = 2'b00;
  localparam logic [1:0] MODE_RELU     = 2'b01;
  localparam logic [1:0] MODE_MAX_POOL = 2'b10;

  typedef logic [3:0] sched_state_t;

  localparam logic [3:0] ST_IDLE     = 4'd0;
  localparam logic [3:0] ST_COLLECT  = 4'd1;
  localparam logic [3:0] ST_LOAD_REQ = 4'd2;
  localparam logic [3:0] ST_BURST    = 4'd3;
  localparam logic [3:0] ST_GAP      = 4'd4;
  localparam logic [3:0] ST_START    = 4'd5;
  localparam logic [3:0] ST_WAIT_HI  = 4'd6;
  localparam logic [3:0] ST_WAIT_LO  = 4'd7;
  localparam logic [3:0] ST_RESPOND  = 4'd8;

  function automatic int mem_size(input int window);
    return 2 * window * window;
  endfunction

endpackage

// File: rtl/cnn_rr_arbiter.sv
// ---------------------------------------------------------------------------
// cnn_rr_arbiter
// Round-robin arbiter. The search for the next grant starts at the index
// just after the most recently granted requester (index 0 after reset).
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   req          : request vector
//   advance      : accept the current grant and move the pointer past it
//   grant        : one-hot grant (combinational, all zero when no req)
// ---------------------------------------------------------------------------
module cnn_rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             found;
  int               sum;
  logic [IDX_W-1:0] cand_idx;

  // Walk the requesters once, starting at the pointer and wrapping at
  // NUM_REQ; the first one found wins.
  always_comb begin
    grant    = '0;
    ptr_d    = ptr_q;
    found    = 1'b0;
    sum      = 0;
    cand_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = int'(ptr_q) + i;
      if (sum >= NUM_REQ) begin
        sum = sum - NUM_REQ;
      end
      cand_idx = IDX_W'(sum);
      if (!found && req[cand_idx]) begin
        found           = 1'b1;
        grant[cand_idx] = 1'b1;
        if (advance) begin
          ptr_d = (sum == NUM_REQ - 1) ? '0 : IDX_W'(sum + 1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/cnn_job_sched.sv
// ---------------------------------------------------------------------------
// cnn_job_sched
// Arbitrates CNN jobs among NUM_REQ requesters. A granted requester streams
// MEM_SIZE bytes (pixels then kernels) into a local buffer; the whole job is
// then burst into the CNN (which cannot stall), the CNN is started, and its
// result is returned to the requester with a one-cycle rsp_valid pulse.
//
// Optional feature: define CNN_SCHED_TIMEOUT_EN to add a watchdog in the
// busy-wait states; on expiry the job answers with rsp_error=1, result 0.
//
// Ports:
//   clk, reset_n                 : clock, asynchronous active-low reset
//   req / req_mode / req_data /
//   req_data_valid               : per-requester job request, mode, byte stream
//   req_data_ready               : byte accepted (granted requester only)
//   rsp_valid                    : one-cycle result strobe to the granted requester
//   rsp_result / rsp_overflow /
//   rsp_error                    : result, CNN overflow, watchdog timeout
//   cnn_load_enable / cnn_data_in /
//   cnn_start / cnn_mode         : CNN load and control
//   cnn_busy / cnn_result /
//   cnn_overflow                 : CNN status and result
// ---------------------------------------------------------------------------
module cnn_job_sched
  import cnn_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int WINDOW    = 3,
  parameter int ACC_WIDTH = 32,
  parameter int TIMEOUT   = 64
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [2*NUM_REQ-1:0] req_mode,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_data_valid,
  output logic [NUM_REQ-1:0]   req_data_ready,
  output logic [NUM_REQ-1:0]   rsp_valid,
  output logic [ACC_WIDTH-1:0] rsp_result,
  output logic                 rsp_overflow,
  output logic                 rsp_error,
  output logic                 cnn_load_enable,
  output logic [7:0]           cnn_data_in,
  output logic                 cnn_start,
  output logic [1:0]           cnn_mode,
  input  logic                 cnn_busy,
  input  logic [ACC_WIDTH-1:0] cnn_result,
  input  logic                 cnn_overflow
);

  localparam int MEM_SIZE = mem_size(WINDOW);
  localparam int ADDR_W   = $clog2(MEM_SIZE);
  localparam int IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(MEM_SIZE - 1);

  // Per-requester views of the packed request buses.
  logic [7:0] req_byte     [NUM_REQ];
  logic [1:0] req_mode_arr [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req_unpack
      assign req_byte[gi]     = req_data[gi*8 +: 8];
      assign req_mode_arr[gi] = req_mode[gi*2 +: 2];
    end
  endgenerate

  sched_state_t state_q, state_d;
  logic [ADDR_W-1:0]    count_q, count_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]     grant_idx_q, grant_idx_d;
  logic [1:0]           mode_q, mode_d;
  logic [ACC_WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic                 rsp_overflow_q, rsp_overflow_d;

`ifdef CNN_SCHED_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd_q, wd_d;
  logic            rsp_error_q, rsp_error_d;
`endif

  // Arbiter
  logic [NUM_REQ-1:0] arb_grant;
  logic               arb_advance;
  logic [IDX_W-1:0]   arb_idx;

  cnn_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req),
    .advance (arb_advance),
    .grant   (arb_grant)
  );

  always_comb begin
    arb_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_grant[i]) begin
        arb_idx = IDX_W'(i);
      end
    end
  end

  // Job buffer: plain array with a registered read port. The read address
  // runs one ahead of the burst index so buffer[k] is on the output during
  // the k-th BURST cycle (address 0 is presented in LOAD_REQ).
  logic [7:0]        buf_mem [MEM_SIZE];
  logic              buf_wr_en;
  logic [ADDR_W-1:0] buf_rd_addr;
  logic [7:0]        buf_rd_q;

  always_comb begin
    buf_rd_addr = '0;
    if (state_q == ST_BURST && count_q != LAST) begin
      buf_rd_addr = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (buf_wr_en) begin
      buf_mem[count_q] <= req_byte[grant_idx_q];
    end
    buf_rd_q <= buf_mem[buf_rd_addr];
  end

  // Scheduler FSM
  always_comb begin
    state_d        = state_q;
    count_d        = count_q;
    grant_d        = grant_q;
    grant_idx_d    = grant_idx_q;
    mode_d         = mode_q;
    rsp_result_d   = rsp_result_q;
    rsp_overflow_d = rsp_overflow_q;
    arb_advance    = 1'b0;
    buf_wr_en      = 1'b0;
`ifdef CNN_SCHED_TIMEOUT_EN
    wd_d           = wd_q;
    rsp_error_d    = rsp_error_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          arb_advance = 1'b1;
          grant_d     = arb_grant;
          grant_idx_d = arb_idx;
          mode_d      = req_mode_arr[arb_idx];
          count_d     = '0;
          state_d     = ST_COLLECT;
        end
      end

      ST_COLLECT: begin
        if (|(req_data_valid & grant_q)) begin
          buf_wr_en = 1'b1;
          if (count_q == LAST) begin
            count_d = '0;
            state_d = ST_LOAD_REQ;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
      end

      ST_LOAD_REQ: begin
        count_d = '0;
        state_d = ST_BURST;
      end

      ST_BURST: begin
        if (count_q == LAST) begin
          count_d = '0;
          state_d = ST_GAP;
        end else begin
          count_d = count_q + 1'b1;
        end
      end

      ST_GAP: begin
        state_d = ST_START;
      end

      ST_START: begin
`ifdef CNN_SCHED_TIMEOUT_EN
        wd_d = '0;
`endif
        state_d = ST_WAIT_HI;
      end

      ST_WAIT_HI: begin
        if (cnn_busy) begin
`ifdef CNN_SCHED_TIMEOUT_EN
          wd_d = '0;
`endif
          state_d = ST_WAIT_LO;
        end
`ifdef CNN_SCHED_TIMEOUT_EN
        else if (wd_q == WD_W'(TIMEOUT - 1)) begin
          rsp_result_d   = '0;
          rsp_overflow_d = 1'b0;
          rsp_error_d    = 1'b1;
          state_d        = ST_RESPOND;
        end else begin
          wd_d = wd_q + 1'b1;
        end
`endif
      end

      ST_WAIT_LO: begin
        if (!cnn_busy) begin
          rsp_result_d   = cnn_result;
          rsp_overflow_d = cnn_overflow;
`ifdef CNN_SCHED_TIMEOUT_EN
          rsp_error_d    = 1'b0;
`endif
          state_d        = ST_RESPOND;
        end
`ifdef CNN_SCHED_TIMEOUT_EN
        else if (wd_q == WD_W'(TIMEOUT - 1)) begin
          rsp_result_d   = '0;
          rsp_overflow_d = 1'b0;
          rsp_error_d    = 1'b1;
          state_d        = ST_RESPOND;
        end else begin
          wd_d = wd_q + 1'b1;
        end
`endif
      end

      ST_RESPOND: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      count_q        <= '0;
      grant_q        <= '0;
      grant_idx_q    <= '0;
      mode_q         <= '0;
      rsp_result_q   <= '0;
      rsp_overflow_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      count_q        <= count_d;
      grant_q        <= grant_d;
      grant_idx_q    <= grant_idx_d;
      mode_q         <= mode_d;
      rsp_result_q   <= rsp_result_d;
      rsp_overflow_q <= rsp_overflow_d;
    end
  end

`ifdef CNN_SCHED_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wd_q        <= '0;
      rsp_error_q <= 1'b0;
    end else begin
      wd_q        <= wd_d;
      rsp_error_q <= rsp_error_d;
    end
  end
  assign rsp_error = rsp_error_q;
`else
  assign rsp_error = 1'b0;
`endif

  // Strobes are decoded from the state so that reset forces them low
  // without waiting for a clock edge.
  assign req_data_ready  = (state_q == ST_COLLECT) ? grant_q : '0;
  assign rsp_valid       = (state_q == ST_RESPOND) ? grant_q : '0;
  assign cnn_load_enable = (state_q == ST_LOAD_REQ);
  assign cnn_start       = (state_q == ST_START);
  assign cnn_data_in     = (state_q == ST_BURST) ? buf_rd_q : 8'd0;
  assign cnn_mode        = mode_q;
  assign rsp_result      = rsp_result_q;
  assign rsp_overflow    = rsp_overflow_q;

endmodule

// File: tb/tb_cnn_job_sched.sv
module tb_cnn_job_sched;
  import cnn_pkg::*;

  localparam int NUM_REQ = 2;
  localparam int NN      = 9;
  localparam int MEMSZ   = 18;
  localparam int LATENCY = 33;   // 18 + 9 + 6

  logic                 clk = 1'b0;
  logic                 reset_n = 1'b1;
  logic [NUM_REQ-1:0]   req = '0;
  logic [2*NUM_REQ-1:0] req_mode = '0;
  logic [8*NUM_REQ-1:0] req_data = '0;
  logic [NUM_REQ-1:0]   req_data_valid = '0;
  logic [NUM_REQ-1:0]   req_data_ready;
  logic [NUM_REQ-1:0]   rsp_valid;
  logic [31:0]          rsp_result;
  logic                 rsp_overflow;
  logic                 rsp_error;
  logic                 cnn_load_enable;
  logic [7:0]           cnn_data_in;
  logic                 cnn_start;
  logic [1:0]           cnn_mode;
  logic                 cnn_busy;
  logic [31:0]          cnn_result = '0;
  logic                 cnn_overflow = 1'b0;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  cnn_job_sched #(
    .NUM_REQ(NUM_REQ), .WINDOW(3), .ACC_WIDTH(32), .TIMEOUT(64)
  ) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .req_mode(req_mode),
    .req_data(req_data), .req_data_valid(req_data_valid),
    .req_data_ready(req_data_ready), .rsp_valid(rsp_valid),
    .rsp_result(rsp_result), .rsp_overflow(rsp_overflow), .rsp_error(rsp_error),
    .cnn_load_enable(cnn_load_enable), .cnn_data_in(cnn_data_in),
    .cnn_start(cnn_start), .cnn_mode(cnn_mode), .cnn_busy(cnn_busy),
    .cnn_result(cnn_result), .cnn_overflow(cnn_overflow)
  );

  // ---------------- CNN behavioural model ----------------
  logic [7:0] cap [MEMSZ];
  int  cap_cnt = 0;
  bit  loading = 1'b0;
  int  load_pulses = 0;
  int  stray = 0;
  int  busy_cnt = 0;
  int  rsp_pulses = 0;
  bit  stuck_busy = 1'b0;

  assign cnn_busy = (busy_cnt > 0);

  function automatic logic [31:0] model_result(input logic [1:0] m);
    logic signed [31:0] sum, p, mx;
    sum = 0;
    mx  = 32'sh8000_0000;
    for (int i = 0; i < NN; i++) begin
      p   = $signed(cap[i]) * $signed(cap[NN + i]);
      sum = sum + p;
      if (p > mx) mx = p;
    end
    case (m)
      MODE_RELU:     return (sum < 0) ? 32'd0 : sum;
      MODE_MAX_POOL: return mx;
      default:       return sum;
    endcase
  endfunction

  function automatic logic model_ovf();
    logic signed [31:0] sum;
    sum = 0;
    for (int i = 0; i < NN; i++) sum = sum + $signed(cap[i]) * $signed(cap[NN + i]);
    return (sum > 32767);
  endfunction

  always @(posedge clk) begin
    if (cnn_load_enable) begin
      loading     <= 1'b1;
      cap_cnt     <= 0;
      load_pulses <= load_pulses + 1;
    end else if (loading) begin
      cap[cap_cnt] <= cnn_data_in;
      if (cap_cnt == MEMSZ - 1) loading <= 1'b0;
      cap_cnt <= cap_cnt + 1;
    end else if (cnn_data_in != 8'd0) begin
      stray <= stray + 1;
    end
    if (cnn_start && !stuck_busy) begin
      cnn_result   <= model_result(cnn_mode);
      cnn_overflow <= model_ovf();
      busy_cnt     <= NN + 1;
    end else if (busy_cnt > 0) begin
      busy_cnt <= busy_cnt - 1;
    end
    if (|rsp_valid) rsp_pulses <= rsp_pulses + 1;
  end

  // ---------------- stimulus helpers ----------------
  logic [7:0] job_bytes [MEMSZ];

  task automatic fill(input logic [7:0] pix, input logic [7:0] ker);
    for (int i = 0; i < NN; i++) begin
      job_bytes[i]      = pix;
      job_bytes[NN + i] = ker;
    end
  endtask

  task automatic feed_job(input int idx, input logic [1:0] mode, input bit toggle);
    int  b;
    int  guard;
    bit  phase;
    b = 0; guard = 0; phase = 1'b0;
    @(negedge clk);
    req[idx] = 1'b1;
    req_mode[idx*2 +: 2] = mode;
    while (b < MEMSZ && guard < 300) begin
      @(negedge clk);
      guard++;
      if (toggle && phase) begin
        req_data_valid[idx] = 1'b0;
      end else begin
        req_data_valid[idx] = 1'b1;
        req_data[idx*8 +: 8] = job_bytes[b];
      end
      phase = !phase;
      if (req_data_valid[idx] && req_data_ready[idx]) begin
        b++;
        req[idx] = 1'b0;   // dropping req mid-job must not abort it
      end
    end
    tests_run++;
    if (b != MEMSZ) begin
      tests_failed++;
      $display("FAIL feed_bytes: accepted %0d bytes, required %0d", b, MEMSZ);
    end
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      req_data_valid = '0;
      lat++;
    end while (rsp_valid == '0 && lat < 400);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #3 reset_n = 1'b0;
    #1;
    tests_run++;
    if ({rsp_valid, req_data_ready, cnn_load_enable, cnn_start, cnn_data_in,
         cnn_mode, rsp_result, rsp_overflow, rsp_error} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: rsp_valid=%b ready=%b load=%b start=%b data=%h mode=%b result=%h",
               rsp_valid, req_data_ready, cnn_load_enable, cnn_start, cnn_data_in, cnn_mode, rsp_result);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_mac();
    int lat, base, mism;
    fill(8'd2, 8'd3);
    base = load_pulses;
    feed_job(0, MODE_MAC, 1'b0);
    wait_rsp(lat);
    tests_run++;
    if (rsp_valid !== 2'b01 || rsp_result !== 32'd54 || rsp_overflow !== 1'b0 || rsp_error !== 1'b0) begin
      tests_failed++;
      $display("FAIL mac_result: valid=%b result=%0d ovf=%b err=%b, required 01/54/0/0",
               rsp_valid, rsp_result, rsp_overflow, rsp_error);
    end
    tests_run++;
    if (lat != LATENCY) begin
      tests_failed++;
      $display("FAIL mac_latency: %0d cycles, required %0d", lat, LATENCY);
    end
    mism = 0;
    for (int i = 0; i < MEMSZ; i++) if (cap[i] !== job_bytes[i]) mism++;
    tests_run++;
    if (mism != 0 || load_pulses - base != 1 || stray != 0) begin
      tests_failed++;
      $display("FAIL mac_burst: byte mismatches=%0d load pulses=%0d stray=%0d, required 0/1/0",
               mism, load_pulses - base, stray);
    end
    @(negedge clk);
    tests_run++;
    if (rsp_valid !== 2'b00 || rsp_result !== 32'd54) begin
      tests_failed++;
      $display("FAIL mac_pulse_hold: valid=%b result=%0d, required 00/54", rsp_valid, rsp_result);
    end
    $display("[TB] job req0 MAC result=%0d latency=%0d", rsp_result, lat);
  endtask

  task automatic test_relu_maxpool();
    int lat;
    fill(8'hFF, 8'd5);
    feed_job(1, MODE_RELU, 1'b0);
    wait_rsp(lat);
    tests_run++;
    if (rsp_valid !== 2'b10 || rsp_result !== 32'd0 || cnn_mode !== MODE_RELU) begin
      tests_failed++;
      $display("FAIL relu_result: valid=%b result=%0d mode=%b, required 10/0/01", rsp_valid, rsp_result, cnn_mode);
    end
    $display("[TB] job req1 ReLU result=%0d", rsp_result);
    for (int i = 0; i < NN; i++) begin
      job_bytes[i]      = 8'(i - 4);
      job_bytes[NN + i] = 8'd1;
    end
    feed_job(0, MODE_MAX_POOL, 1'b0);
    wait_rsp(lat);
    tests_run++;
    if (rsp_valid !== 2'b01 || rsp_result !== 32'd4 || cnn_mode !== MODE_MAX_POOL) begin
      tests_failed++;
      $display("FAIL maxpool_result: valid=%b result=%0d mode=%b, required 01/4/10", rsp_valid, rsp_result, cnn_mode);
    end
    $display("[TB] job req0 MaxPool result=%0d", rsp_result);
  endtask

  task automatic test_overflow();
    int lat;
    fill(8'd100, 8'd100);
    feed_job(1, MODE_MAC, 1'b0);
    wait_rsp(lat);
    tests_run++;
    if (rsp_valid !== 2'b10 || rsp_result !== 32'd90000 || rsp_overflow !== 1'b1) begin
      tests_failed++;
      $display("FAIL overflow_capture: valid=%b result=%0d ovf=%b, required 10/90000/1",
               rsp_valid, rsp_result, rsp_overflow);
    end
    $display("[TB] job req1 MAC overflow result=%0d ovf=%b", rsp_result, rsp_overflow);
  endtask

  task automatic test_toggle_valid();
    int lat, base, mism;
    for (int i = 0; i < NN; i++) begin
      job_bytes[i]      = 8'(i + 1);
      job_bytes[NN + i] = 8'd2;
    end
    base = load_pulses;
    feed_job(0, MODE_MAC, 1'b1);
    wait_rsp(lat);
    mism = 0;
    for (int i = 0; i < MEMSZ; i++) if (cap[i] !== job_bytes[i]) mism++;
    tests_run++;
    if (mism != 0 || load_pulses - base != 1) begin
      tests_failed++;
      $display("FAIL toggle_burst: byte mismatches=%0d load pulses=%0d, required 0/1", mism, load_pulses - base);
    end
    tests_run++;
    if (rsp_valid !== 2'b01 || rsp_result !== 32'd90 || lat != LATENCY) begin
      tests_failed++;
      $display("FAIL toggle_result: valid=%b result=%0d latency=%0d, required 01/90/%0d",
               rsp_valid, rsp_result, lat, LATENCY);
    end
    $display("[TB] job req0 toggled-valid result=%0d latency=%0d", rsp_result, lat);
  endtask

  task automatic test_reset_mid_burst();
    int guard, base, lat;
    fill(8'd1, 8'd1);
    feed_job(1, MODE_RELU, 1'b0);
    guard = 0;
    while (!cnn_load_enable && guard < 20) begin @(negedge clk); guard++; end
    tests_run++;
    if (!cnn_load_enable) begin
      tests_failed++;
      $display("FAIL midreset_load: load_enable=%b, required 1", cnn_load_enable);
    end
    repeat (5) @(negedge clk);
    base = rsp_pulses;
    reset_n = 1'b0;
    #1;
    tests_run++;
    if ({rsp_valid, req_data_ready, cnn_load_enable, cnn_start, cnn_data_in,
         cnn_mode, rsp_result, rsp_overflow, rsp_error} !== '0) begin
      tests_failed++;
      $display("FAIL midreset_outputs: data=%h mode=%b result=%0d load=%b, required all 0",
               cnn_data_in, cnn_mode, rsp_result, cnn_load_enable);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (60) @(negedge clk);
    tests_run++;
    if (rsp_pulses != base) begin
      tests_failed++;
      $display("FAIL midreset_no_rsp: %0d rsp pulses, required 0", rsp_pulses - base);
    end
    fill(8'd2, 8'd3);
    feed_job(0, MODE_MAC, 1'b0);
    wait_rsp(lat);
    tests_run++;
    if (rsp_valid !== 2'b01 || rsp_result !== 32'd54 || lat != LATENCY) begin
      tests_failed++;
      $display("FAIL midreset_next_job: valid=%b result=%0d latency=%0d, required 01/54/%0d",
               rsp_valid, rsp_result, lat, LATENCY);
    end
    $display("[TB] job after mid-burst reset result=%0d", rsp_result);
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [1:0]  exp_v;
    logic [31:0] exp_r;
    apply_reset();
    @(negedge clk);
    req_data       = {8'd2, 8'd1};
    req_mode       = {MODE_MAC, MODE_MAC};
    req_data_valid = 2'b11;
    req            = 2'b11;
    for (int j = 0; j < 4; j++) begin
      lat = 0;
      do begin @(negedge clk); lat++; end while (rsp_valid == '0 && lat < 400);
      exp_v = (j % 2 == 0) ? 2'b01 : 2'b10;
      exp_r = (j % 2 == 0) ? 32'd9 : 32'd36;
      tests_run++;
      if (rsp_valid !== exp_v || rsp_result !== exp_r) begin
        tests_failed++;
        $display("FAIL rr_job%0d: valid=%b result=%0d, required %b/%0d", j, rsp_valid, rsp_result, exp_v, exp_r);
      end
      $display("[TB] rr job %0d rsp_valid=%b result=%0d", j, rsp_valid, rsp_result);
    end
    req = '0;
    req_data_valid = '0;
    repeat (40) @(negedge clk);
  endtask

`ifdef CNN_SCHED_TIMEOUT_EN
  task automatic test_timeout();
    int guard, cyc;
    stuck_busy = 1'b1;
    fill(8'd1, 8'd1);
    feed_job(0, MODE_MAC, 1'b0);
    guard = 0;
    while (!cnn_start && guard < 50) begin @(negedge clk); req_data_valid = '0; guard++; end
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (rsp_valid == '0 && cyc < 300);
    tests_run++;
    if (rsp_valid !== 2'b01 || rsp_error !== 1'b1 || rsp_result !== 32'd0 || cyc != 65) begin
      tests_failed++;
      $display("FAIL timeout: valid=%b err=%b result=%0d cycles=%0d, required 01/1/0/65",
               rsp_valid, rsp_error, rsp_result, cyc);
    end
    $display("[TB] timeout job err=%b after %0d cycles", rsp_error, cyc);
    stuck_busy = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_mac();
    test_relu_maxpool();
    test_overflow();
    test_toggle_valid();
    test_reset_mid_burst();
    test_back_to_back();
`ifdef CNN_SCHED_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
